// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-to-parallel frame controller.
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sipo_state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_en.sv
// Serial-in shift register. A load restarts the register from the incoming
// first bit; otherwise each enabled cycle shifts the bit in at the LSB.
module sipo_shift_en #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_en,
  input  logic             i_load,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_sr
);

  logic [WIDTH-1:0] r_sr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sr <= '0;
    end else if (i_en) begin
      if (i_load) begin
        r_sr <= {{(WIDTH-1){1'b0}}, i_bit};
      end else begin
        r_sr <= {r_sr[WIDTH-2:0], i_bit};
      end
    end
  end

  assign o_sr = r_sr;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame controller: aligns serial bits to SOF, counts bits per word and hands
// completed words to a consumer through a one-entry valid/ready register.
module sipo_frame_ctrl
  import sipo_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             ser_sof,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             sync_err,
  output logic             overrun,
  input  logic             clr_overrun
);

  sipo_state_t      r_state;
  sipo_state_t      w_next_state;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic [WIDTH-1:0] w_sr;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_sync_err;
  logic             r_overrun;
  logic             w_sof;
  logic             w_in_shift;
  logic             w_complete;
  logic             w_resync;
  logic             w_load_ok;
  logic             w_unused_msb;

  assign w_sof      = ser_valid & ser_sof;
  assign w_in_shift = (r_state == SHIFT);
  assign w_resync   = w_in_shift & w_sof;
  assign w_complete = w_in_shift & ser_valid & ~ser_sof &
                      (r_bit_cnt == CNT_W'(WIDTH - 1));
  assign w_word     = {w_sr[WIDTH-2:0], ser_in};
  assign w_load_ok  = ~r_out_valid | out_ready;

  // The stored MSB is the bit that falls out when the word completes.
  assign w_unused_msb = w_sr[WIDTH-1];

  sipo_shift_en #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (ser_valid),
    .i_load  (w_sof),
    .i_bit   (ser_in),
    .o_sr    (w_sr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_next_state;
      r_bit_cnt <= w_next_cnt;
    end
  end

  // SOF inside a frame is always a resync, never a completion.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_bit_cnt;
    case (r_state)
      IDLE: begin
        if (w_sof) begin
          w_next_state = SHIFT;
          w_next_cnt   = CNT_W'(1);
        end
      end
      SHIFT: begin
        if (w_sof) begin
          w_next_cnt = CNT_W'(1);
        end else if (w_complete) begin
          w_next_state = IDLE;
          w_next_cnt   = '0;
        end else if (ser_valid) begin
          w_next_cnt = r_bit_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  always_comb begin
    busy = (r_state == SHIFT);
  end

  // A pop and a load in the same cycle keep out_valid high with the new word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_complete && w_load_ok) begin
      r_out_data  <= w_word;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync_err <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_sync_err <= w_resync;
      if (w_complete && !w_load_ok) begin
        r_overrun <= 1'b1;
      end else if (clr_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign bit_cnt   = r_bit_cnt;
  assign sync_err  = r_sync_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl with a queue-based frame model checked
// every cycle, plus literal expectations for each scenario.
module tb_sipo_frame_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk         = 1'b0;
  logic             reset_n     = 1'b0;
  logic             ser_in      = 1'b0;
  logic             ser_valid   = 1'b0;
  logic             ser_sof     = 1'b0;
  logic             out_ready   = 1'b0;
  logic             clr_overrun = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             busy;
  logic [CNT_W-1:0] bit_cnt;
  logic             sync_err;
  logic             overrun;

  int checks   = 0;
  int failures = 0;
  bit compareOn = 1'b0;

  always #5 clk = ~clk;

  sipo_frame_ctrl #(
    .WIDTH (WIDTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ser_in      (ser_in),
    .ser_valid   (ser_valid),
    .ser_sof     (ser_sof),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .bit_cnt     (bit_cnt),
    .sync_err    (sync_err),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  // Model: a frame is a list of received bits; a word is their binary value.
  bit   mBits[$];
  bit   mInFrame = 1'b0;
  int   mData    = 0;
  bit   mValid   = 1'b0;
  bit   mSync    = 1'b0;
  bit   mOver    = 1'b0;

  always @(posedge clk or negedge reset_n) begin : model
    bit completed;
    bit blocked;
    bit syncNow;
    int value;
    if (!reset_n) begin
      mBits.delete();
      mInFrame = 1'b0;
      mData    = 0;
      mValid   = 1'b0;
      mSync    = 1'b0;
      mOver    = 1'b0;
    end else begin
      completed = 1'b0;
      syncNow   = 1'b0;
      value     = 0;
      if (ser_valid) begin
        if (ser_sof) begin
          syncNow = mInFrame;
          mBits.delete();
          mBits.push_back(ser_in);
          mInFrame = 1'b1;
        end else if (mInFrame) begin
          mBits.push_back(ser_in);
          if (mBits.size() == WIDTH) begin
            foreach (mBits[i]) value = value * 2 + int'(mBits[i]);
            completed = 1'b1;
            mBits.delete();
            mInFrame = 1'b0;
          end
        end
      end
      blocked = completed && mValid && !out_ready;
      if (completed && !blocked) begin
        mData  = value;
        mValid = 1'b1;
      end else if (mValid && out_ready) begin
        mValid = 1'b0;
      end
      if (blocked) mOver = 1'b1;
      else if (clr_overrun) mOver = 1'b0;
      mSync = syncNow;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (compareOn) begin
      checkOutput("cyc_out_valid", 32'(out_valid), 32'(mValid));
      checkOutput("cyc_out_data",  32'(out_data),  32'(mData));
      checkOutput("cyc_busy",      32'(busy),      32'(mInFrame));
      checkOutput("cyc_bit_cnt",   32'(bit_cnt),   32'(mBits.size()));
      checkOutput("cyc_sync_err",  32'(sync_err),  32'(mSync));
      checkOutput("cyc_overrun",   32'(overrun),   32'(mOver));
    end
  end

  task automatic applyStimulus(input logic v, input logic sof, input logic b,
                               input logic rdy, input logic clr);
    ser_valid   = v;
    ser_sof     = sof;
    ser_in      = b;
    out_ready   = rdy;
    clr_overrun = clr;
    @(negedge clk);
  endtask

  task automatic sendFrame(input logic [WIDTH-1:0] w, input logic rdy,
                           input logic lastRdy, input logic lastClr);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      applyStimulus(1'b1, i == WIDTH - 1, w[i], (i == 0) ? lastRdy : rdy,
                    (i == 0) ? lastClr : 1'b0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data",  32'(out_data),  32'd0);
    checkOutput("rst_busy",      32'(busy),      32'd0);
    checkOutput("rst_bit_cnt",   32'(bit_cnt),   32'd0);
    reset_n   = 1'b1;
    compareOn = 1'b1;

    // Basic frame 1011 with the consumer always ready
    applyStimulus(1, 1, 1, 1, 0);
    checkOutput("t1_busy_1", 32'(busy), 32'd1);
    checkOutput("t1_cnt_1",  32'(bit_cnt), 32'd1);
    applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(1, 0, 1, 1, 0);
    checkOutput("t1_busy_3", 32'(busy), 32'd1);
    checkOutput("t1_cnt_3",  32'(bit_cnt), 32'd3);
    applyStimulus(1, 0, 1, 1, 0);
    checkOutput("t1_valid", 32'(out_valid), 32'd1);
    checkOutput("t1_data",  32'(out_data), 32'hB);
    checkOutput("t1_busy_done", 32'(busy), 32'd0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("t1_popped", 32'(out_valid), 32'd0);

    // Stray bits, then 0110 with gaps between bits
    applyStimulus(1, 0, 1, 1, 0);
    applyStimulus(1, 0, 1, 1, 0);
    checkOutput("t2_stray_busy", 32'(busy), 32'd0);
    checkOutput("t2_stray_cnt",  32'(bit_cnt), 32'd0);
    applyStimulus(1, 1, 0, 1, 0);
    applyStimulus(0, 0, 1, 1, 0);
    checkOutput("t2_gap_cnt", 32'(bit_cnt), 32'd1);
    applyStimulus(1, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("t2_gap_cnt2", 32'(bit_cnt), 32'd2);
    applyStimulus(1, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("t2_valid", 32'(out_valid), 32'd1);
    checkOutput("t2_data",  32'(out_data), 32'h6);
    applyStimulus(0, 0, 0, 1, 0);

    // Backpressure, overrun, set beats clear, then pop and clear
    sendFrame(4'hC, 1'b0, 1'b0, 1'b0);
    checkOutput("t3_held_valid", 32'(out_valid), 32'd1);
    sendFrame(4'h3, 1'b0, 1'b0, 1'b0);
    checkOutput("t3_held_data", 32'(out_data), 32'hC);
    checkOutput("t3_overrun",   32'(overrun), 32'd1);
    sendFrame(4'hF, 1'b0, 1'b0, 1'b1);
    checkOutput("t3_set_wins",  32'(overrun), 32'd1);
    checkOutput("t3_still_c",   32'(out_data), 32'hC);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("t3_popped",    32'(out_valid), 32'd0);
    checkOutput("t3_ovr_kept",  32'(overrun), 32'd1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t3_ovr_clr",   32'(overrun), 32'd0);

    // Pop and load in the same cycle
    sendFrame(4'h9, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_hold_9", 32'(out_data), 32'h9);
    sendFrame(4'h5, 1'b0, 1'b1, 1'b0);
    checkOutput("t4_valid",   32'(out_valid), 32'd1);
    checkOutput("t4_data",    32'(out_data), 32'h5);
    checkOutput("t4_overrun", 32'(overrun), 32'd0);
    applyStimulus(0, 0, 0, 1, 0);

    // Resync: partial 11 dropped, 0010 delivered
    applyStimulus(1, 1, 1, 1, 0);
    applyStimulus(1, 0, 1, 1, 0);
    checkOutput("t5_cnt_2", 32'(bit_cnt), 32'd2);
    applyStimulus(1, 1, 0, 1, 0);
    checkOutput("t5_sync_err", 32'(sync_err), 32'd1);
    checkOutput("t5_cnt_1",    32'(bit_cnt), 32'd1);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("t5_sync_once", 32'(sync_err), 32'd0);
    applyStimulus(1, 0, 1, 1, 0);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("t5_data", 32'(out_data), 32'h2);
    checkOutput("t5_valid", 32'(out_valid), 32'd1);
    applyStimulus(0, 0, 0, 1, 0);

    // Reset mid-frame with a word held
    sendFrame(4'hA, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 1, 1, 0, 0);
    applyStimulus(1, 0, 1, 0, 0);
    checkOutput("t6_pre_cnt", 32'(bit_cnt), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_rst_data",  32'(out_data), 32'd0);
    checkOutput("t6_rst_busy",  32'(busy), 32'd0);
    checkOutput("t6_rst_cnt",   32'(bit_cnt), 32'd0);
    checkOutput("t6_rst_sync",  32'(sync_err), 32'd0);
    checkOutput("t6_rst_ovr",   32'(overrun), 32'd0);
    ser_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    sendFrame(4'hE, 1'b1, 1'b1, 1'b0);
    checkOutput("t6_data",  32'(out_data), 32'hE);
    checkOutput("t6_valid", 32'(out_valid), 32'd1);
    applyStimulus(0, 0, 0, 1, 0);

    compareOn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
